// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART transmit arbiter
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_LO,
        WAIT_HI
    } arb_state_t;

    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational round-robin picker, searches upward from ptr with wrap
module uart_rr_pick #(
    parameter int N = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = '0;
        for (int k = 0; k < N; k++) begin
            // explicit wrap keeps non-power-of-two N correct
            j = (int'(ptr) + k >= N) ? IDX_W'(int'(ptr) + k - N) : IDX_W'(int'(ptr) + k);
            if (!any && req[j]) begin
                gnt[j] = 1'b1;
                idx    = j;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - packet-locking round-robin arbiter sharing one UART byte transmitter
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N            = 4,
    parameter int LOCK_TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N-1:0]             req_valid,
    input  logic [UART_DATA_W*N-1:0] req_data,
    input  logic [N-1:0]             req_last,
    output logic [N-1:0]             req_ready,
    output logic [N-1:0]             grant,
    output logic                     tx_send,
    output logic [UART_DATA_W-1:0]   tx_data,
    input  logic                     tx_cts,
    output logic                     lock_drop
);

    localparam int          IDX_W    = $clog2(N);
    localparam logic [15:0] TMO_LAST = 16'(LOCK_TIMEOUT - 1);

    arb_state_t             state, state_nx;
    logic                   locked;
    logic [IDX_W-1:0]       owner;
    logic [IDX_W-1:0]       rr_ptr;
    logic [15:0]            tmo_cnt;
    logic                   last_q;

    logic [N-1:0]           pick_gnt;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic                   accept;
    logic [IDX_W-1:0]       accept_idx;
    logic [UART_DATA_W-1:0] sel_data;
    logic                   sel_last;
    logic                   idle_wait;
    logic                   release_last;
    logic [IDX_W-1:0]       next_ptr;

    uart_rr_pick #(.N(N)) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // while locked only the owner is eligible; others wait for the release
    always_comb begin
        req_ready  = '0;
        accept     = 1'b0;
        accept_idx = owner;
        if (!rst && state == IDLE && tx_cts) begin
            if (locked) begin
                if (req_valid[owner]) begin
                    req_ready[owner] = 1'b1;
                    accept           = 1'b1;
                end
            end else if (pick_any) begin
                req_ready  = pick_gnt;
                accept     = 1'b1;
                accept_idx = pick_idx;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (accept_idx == IDX_W'(i)) begin
                sel_data = req_data[UART_DATA_W*i +: UART_DATA_W];
                sel_last = req_last[i];
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)  state_nx = SEND;
            SEND:                 state_nx = WAIT_LO;
            WAIT_LO: if (!tx_cts) state_nx = WAIT_HI;
            WAIT_HI: if (tx_cts)  state_nx = IDLE;
            default:              state_nx = IDLE;
        endcase
    end

    assign idle_wait    = (state == IDLE) && locked && !req_valid[owner];
    assign release_last = (state == WAIT_HI) && tx_cts && last_q;
    assign next_ptr     = IDX_W'(wrap_inc(int'(owner), N));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            locked    <= 1'b0;
            owner     <= '0;
            rr_ptr    <= '0;
            tmo_cnt   <= '0;
            last_q    <= 1'b0;
            grant     <= '0;
            tx_send   <= 1'b0;
            tx_data   <= '0;
            lock_drop <= 1'b0;
        end else begin
            state     <= state_nx;
            tx_send   <= accept;
            lock_drop <= 1'b0;
            if (accept) begin
                locked  <= 1'b1;
                owner   <= accept_idx;
                grant   <= req_ready;
                tx_data <= sel_data;
                last_q  <= sel_last;
                tmo_cnt <= '0;
            end else if (idle_wait) begin
                if (tmo_cnt == TMO_LAST) begin
                    locked    <= 1'b0;
                    grant     <= '0;
                    rr_ptr    <= next_ptr;
                    lock_drop <= 1'b1;
                    tmo_cnt   <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                end
            end
            if (release_last) begin
                locked <= 1'b0;
                grant  <= '0;
                rr_ptr <= next_ptr;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - scoreboard bench for uart_tx_arb with a behavioural UART transmitter
module tb_uart_tx_arb;

    localparam int N  = 4;
    localparam int LT = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           tx_send;
    logic [7:0]     tx_data;
    logic           tx_cts;
    logic           lock_drop;

    always #5 clk = ~clk;

    uart_tx_arb #(.N(N), .LOCK_TIMEOUT(LT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .tx_send   (tx_send),
        .tx_data   (tx_data),
        .tx_cts    (tx_cts),
        .lock_drop (lock_drop)
    );

    typedef struct {int idx; logic [7:0] d; logic l;} src_t;
    typedef struct {int idx; logic [7:0] d;} exp_t;

    src_t         src_q[$];
    exp_t         exp_q[$];
    logic [N-1:0] pend;
    logic         cts_hold = 1'b0;
    int           busy;
    int           cyc = 0;
    int           total = 0;
    int           passed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic push(input int idx, input logic [7:0] d, input logic l);
        src_t s;
        exp_t e;
        s.idx = idx; s.d = d; s.l = l;
        e.idx = idx; e.d = d;
        src_q.push_back(s);
        exp_q.push_back(e);
    endtask

    // requester sources: retire accepted bytes, present the next head per requester
    initial begin
        pend      = '0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (pend[i]) begin
                    for (int j = 0; j < src_q.size(); j++) begin
                        if (src_q[j].idx == i) begin
                            src_q.delete(j);
                            break;
                        end
                    end
                end
            end
            req_valid = '0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < src_q.size(); j++) begin
                    if (src_q[j].idx == i) begin
                        req_valid[i]       = 1'b1;
                        req_data[8*i +: 8] = src_q[j].d;
                        req_last[i]        = src_q[j].l;
                        break;
                    end
                end
            end
            #1;
            pend = req_ready;
        end
    end

    // transmitter model: busy for 3 cycles after each send strobe
    initial begin
        busy   = 0;
        tx_cts = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_send) busy = 3;
            else if (busy > 0) busy--;
            tx_cts = (busy == 0) && !cts_hold;
        end
    end

    // monitor: every send strobe must match the next expected byte and owner
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (tx_send) begin
                check("send_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("tx_data", tx_data, e.d);
                    check("grant_at_send", grant, 1 << e.idx);
                end
            end
        end
    end

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || src_q.size() != 0 || !tx_cts) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, 32'(n < 300), 1);
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int n;
        int t0;
        logic seen_ready;
        logic seen_send;

        rst = 1'b1;
        push(2, 8'hA5, 1'b1);
        repeat (3) @(negedge clk);
        check("reset_req_ready", req_ready, 0);
        check("reset_tx_send", tx_send, 0);
        check("reset_tx_data", tx_data, 8'h00);
        check("reset_grant", grant, 0);
        check("reset_lock_drop", lock_drop, 0);
        rst = 1'b0;
        drain("single");
        check("single_grant_released", grant, 0);
        check("single_rr_ptr", dut.rr_ptr, 3);

        rst = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++)
                push(i, 8'(8'h10 * (r + 1) + i), 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drain("fairness");
        check("fairness_rr_ptr", dut.rr_ptr, 0);

        push(1, 8'h11, 1'b0);
        push(1, 8'h22, 1'b0);
        push(1, 8'h33, 1'b1);
        repeat (3) @(negedge clk);
        push(0, 8'h55, 1'b1);
        drain("atomic");

        // SEND at S, WAIT_LO S+1, WAIT_HI S+2..S+3, IDLE S+4..S+11, drop pulse at S+12
        src_q.push_back('{idx: 3, d: 8'h3C, l: 1'b0});
        exp_q.push_back('{idx: 3, d: 8'h3C});
        n = 0;
        while (!tx_send && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("timeout_first_send_seen", 32'(n < 20), 1);
        t0 = cyc;
        push(0, 8'h0A, 1'b1);
        n = 0;
        while (!lock_drop && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("lock_drop_delay", cyc - t0, 12);
        check("grant_after_drop", grant, 0);
        @(negedge clk);
        check("lock_drop_single_pulse", lock_drop, 0);
        drain("timeout");

        cts_hold = 1'b1;
        repeat (2) @(negedge clk);
        push(1, 8'h77, 1'b1);
        push(2, 8'h88, 1'b1);
        seen_ready = 1'b0;
        seen_send  = 1'b0;
        repeat (10) begin
            @(negedge clk);
            #2;
            seen_ready = seen_ready | (req_ready != 0);
            seen_send  = seen_send | tx_send;
        end
        check("backpressure_ready", seen_ready, 0);
        check("backpressure_send", seen_send, 0);
        cts_hold = 1'b0;
        drain("backpressure");

        push(2, 8'h99, 1'b1);
        n = 0;
        while (!tx_send && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("midbyte_send_seen", 32'(n < 20), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #2;
        check("midbyte_tx_send", tx_send, 0);
        check("midbyte_tx_data", tx_data, 8'h00);
        check("midbyte_grant", grant, 0);
        check("midbyte_lock_drop", lock_drop, 0);
        check("midbyte_req_ready", req_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        seen_send = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen_send = seen_send | tx_send;
        end
        check("midbyte_no_reissue", seen_send, 0);
        push(1, 8'h42, 1'b1);
        drain("after_reset");

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d/%0d", passed, total);
        $fatal(1);
    end

endmodule
